// File: rtl/pll_rst_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// State encodings are fixed because they are exported on the debug port.
package pll_rst_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_WAIT_LOCK = 3'd0;
    localparam state_t ST_HOLD      = 3'd1;
    localparam state_t ST_RELEASE   = 3'd2;
    localparam state_t ST_RUN       = 3'd3;
    localparam state_t ST_ASSERT    = 3'd4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_rst_seq_sync_ff.sv
// Parameterized-depth bit synchronizer with async active-low clear.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_sync <= '0;
        else         r_sync <= {r_sync[STAGES-2:0], d};
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// Staged reset sequencer driven by a filtered PLL lock indication.
// FSM registers feed a final output register stage.
module pll_rst_seq
    import pll_rst_seq_pkg::*;
#(
    parameter int LOCK_SYNC_STAGES = 2,
    parameter int LOCK_HOLD        = 1024,
    parameter int STAGES           = 3,
    parameter int STAGE_GAP        = 16,
    parameter int MIN_ASSERT       = 64,
    parameter int CNT_W            = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              pll_locked,
    input  logic              soft_rst,
    input  logic              clr_lost,
    output logic [STAGES-1:0] rst_out_n,
    output logic              ready,
    output logic              lock_lost,
    output logic [CNT_W-1:0]  loss_count,
    output logic [2:0]        state
);

    localparam int CW = $clog2(max3(LOCK_HOLD, STAGE_GAP, MIN_ASSERT) + 1);
    localparam int IW = (STAGES > 1) ? $clog2(STAGES) : 1;

    logic              w_lk;
    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    logic [STAGES-1:0] r_rel;
    logic              r_loss;

    sync_ff #(.STAGES(LOCK_SYNC_STAGES)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (pll_locked),
        .q      (w_lk)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_WAIT_LOCK;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rel   <= '0;
            r_loss  <= 1'b0;
        end else begin
            r_loss <= 1'b0;
            unique case (r_state)
                ST_WAIT_LOCK: begin
                    if (w_lk) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= CW'(LOCK_HOLD - 1);
                    end
                end
                ST_HOLD: begin
                    if (!w_lk) begin
                        r_state <= ST_WAIT_LOCK;
                    end else if (soft_rst) begin
                        r_state <= ST_ASSERT;
                        r_cnt   <= CW'(MIN_ASSERT - 1);
                    end else if (r_cnt == '0) begin
                        r_rel   <= STAGES'(1);
                        r_idx   <= IW'(1);
                        r_cnt   <= CW'(STAGE_GAP - 1);
                        r_state <= (STAGES == 1) ? ST_RUN : ST_RELEASE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_RELEASE: begin
                    // Lock loss outranks a coincident soft reset.
                    if (!w_lk || soft_rst) begin
                        r_state <= ST_ASSERT;
                        r_cnt   <= CW'(MIN_ASSERT - 1);
                        r_rel   <= '0;
                        r_loss  <= !w_lk;
                    end else if (r_cnt == '0) begin
                        r_rel <= r_rel | (STAGES'(1) << r_idx);
                        r_idx <= r_idx + IW'(1);
                        r_cnt <= CW'(STAGE_GAP - 1);
                        if (r_idx == IW'(STAGES - 1)) r_state <= ST_RUN;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_RUN: begin
                    if (!w_lk || soft_rst) begin
                        r_state <= ST_ASSERT;
                        r_cnt   <= CW'(MIN_ASSERT - 1);
                        r_rel   <= '0;
                        r_loss  <= !w_lk;
                    end
                end
                ST_ASSERT: begin
                    if (r_cnt == '0) r_state <= ST_WAIT_LOCK;
                    else             r_cnt   <= r_cnt - CW'(1);
                end
                default: begin
                    r_state <= ST_WAIT_LOCK;
                    r_rel   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_out_n  <= '0;
            ready      <= 1'b0;
            lock_lost  <= 1'b0;
            loss_count <= '0;
        end else begin
            rst_out_n <= r_rel;
            ready     <= (r_state == ST_RUN);
            if (r_loss)        lock_lost <= 1'b1;
            else if (clr_lost) lock_lost <= 1'b0;
            if (r_loss && (loss_count != '1))
                loss_count <= loss_count + CNT_W'(1);
        end
    end

    assign state = r_state;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq with small timing parameters.
module tb_pll_rst_seq;

    logic       clk;
    logic       resetn;
    logic       pll_locked;
    logic       soft_rst;
    logic       clr_lost;
    logic [2:0] rst_out_n;
    logic       ready;
    logic       lock_lost;
    logic [1:0] loss_count;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;

    pll_rst_seq #(
        .LOCK_SYNC_STAGES (2),
        .LOCK_HOLD        (8),
        .STAGES           (3),
        .STAGE_GAP        (4),
        .MIN_ASSERT       (5),
        .CNT_W            (2)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pll_locked (pll_locked),
        .soft_rst   (soft_rst),
        .clr_lost   (clr_lost),
        .rst_out_n  (rst_out_n),
        .ready      (ready),
        .lock_lost  (lock_lost),
        .loss_count (loss_count),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        pll_locked = 1'b0;
        soft_rst   = 1'b0;
        clr_lost   = 1'b0;
        resetn     = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        pll_locked = 1'b0;
        soft_rst   = 1'b0;
        clr_lost   = 1'b0;
        resetn     = 1'b0;
        #3;
        n_cmp++;
        if ({rst_out_n, ready, lock_lost, loss_count, state} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_vals got rst=%b rdy=%b lost=%b cnt=%0d st=%0d want all 0",
                     rst_out_n, ready, lock_lost, loss_count, state);
        end
        step();
        resetn = 1'b1;
        step();
        n_cmp++;
        if (state !== 3'd0 || rst_out_n !== 3'b000) begin
            n_err++;
            $display("FAIL reset_idle got st=%0d rst=%b want 0/000", state, rst_out_n);
        end
    endtask

    task automatic test_clean_lock();
        logic [2:0] e_rst;
        logic [2:0] e_st;
        pll_locked = 1'b1;
        for (int c = 0; c <= 19; c++) begin
            step();
            e_rst = (c >= 19) ? 3'b111 : (c >= 15) ? 3'b011 :
                    (c >= 11) ? 3'b001 : 3'b000;
            e_st  = (c >= 18) ? 3'd3 : (c >= 10) ? 3'd2 :
                    (c >= 2) ? 3'd1 : 3'd0;
            n_cmp++;
            if (rst_out_n !== e_rst || ready !== (c >= 19) || state !== e_st) begin
                n_err++;
                $display("FAIL clean_lock c=%0d got rst=%b rdy=%b st=%0d want rst=%b rdy=%b st=%0d",
                         c, rst_out_n, ready, state, e_rst, (c >= 19), e_st);
            end
        end
    endtask

    task automatic test_glitch_hold();
        logic [2:0] e_rst;
        do_reset();
        pll_locked = 1'b1;
        for (int c = 0; c <= 25; c++) begin
            step();
            if (c == 4) pll_locked = 1'b0;
            if (c == 5) pll_locked = 1'b1;
            e_rst = (c >= 25) ? 3'b111 : (c >= 21) ? 3'b011 :
                    (c >= 17) ? 3'b001 : 3'b000;
            n_cmp++;
            if (rst_out_n !== e_rst) begin
                n_err++;
                $display("FAIL glitch_hold c=%0d got rst=%b want %b", c, rst_out_n, e_rst);
            end
        end
        n_cmp++;
        if (loss_count !== 2'd0 || lock_lost !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_noloss got cnt=%0d lost=%b want 0/0", loss_count, lock_lost);
        end
    endtask

    task automatic test_loss_run();
        logic [2:0] e_st;
        pll_locked = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            step();
            e_st = (c >= 7) ? 3'd0 : (c >= 2) ? 3'd4 : 3'd3;
            n_cmp++;
            if (rst_out_n !== ((c >= 3) ? 3'b000 : 3'b111) ||
                ready !== (c < 3) || lock_lost !== (c >= 3) || state !== e_st) begin
                n_err++;
                $display("FAIL loss_run c=%0d got rst=%b rdy=%b lost=%b st=%0d want st=%0d",
                         c, rst_out_n, ready, lock_lost, state, e_st);
            end
        end
        n_cmp++;
        if (loss_count !== 2'd1) begin
            n_err++;
            $display("FAIL loss_count1 got %0d want 1", loss_count);
        end
    endtask

    task automatic lose_once(input logic [1:0] e_cnt, input logic with_clr);
        int i;
        pll_locked = 1'b1;
        i = 0;
        while (i < 60 && !ready) begin
            step();
            i++;
        end
        n_cmp++;
        if (!ready) begin
            n_err++;
            $display("FAIL relock_timeout got ready=%b want 1 within 60", ready);
        end
        pll_locked = 1'b0;
        step();
        step();
        step();
        if (with_clr) clr_lost = 1'b1;
        step();
        clr_lost = 1'b0;
        n_cmp++;
        if (loss_count !== e_cnt || lock_lost !== 1'b1) begin
            n_err++;
            $display("FAIL loss_sat got cnt=%0d lost=%b want cnt=%0d lost=1",
                     loss_count, lock_lost, e_cnt);
        end
    endtask

    task automatic test_saturate_clear();
        lose_once(2'd2, 1'b0);
        lose_once(2'd3, 1'b0);
        lose_once(2'd3, 1'b1);
        clr_lost = 1'b1;
        step();
        clr_lost = 1'b0;
        n_cmp++;
        if (lock_lost !== 1'b0 || loss_count !== 2'd3) begin
            n_err++;
            $display("FAIL clr_lost got lost=%b cnt=%0d want 0/3", lock_lost, loss_count);
        end
    endtask

    task automatic test_soft_rst();
        int i;
        logic [2:0] e_rst;
        logic [2:0] e_st;
        pll_locked = 1'b1;
        i = 0;
        while (i < 60 && !ready) begin
            step();
            i++;
        end
        n_cmp++;
        if (!ready) begin
            n_err++;
            $display("FAIL soft_lock_timeout got ready=%b want 1", ready);
        end
        soft_rst = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            step();
            if (c == 2) soft_rst = 1'b0;
            e_rst = (c >= 15) ? 3'b001 : (c >= 1) ? 3'b000 : 3'b111;
            e_st  = (c >= 14) ? 3'd2 : (c >= 6) ? 3'd1 :
                    (c >= 5) ? 3'd0 : 3'd4;
            n_cmp++;
            if (rst_out_n !== e_rst || state !== e_st) begin
                n_err++;
                $display("FAIL soft_rst c=%0d got rst=%b st=%0d want rst=%b st=%0d",
                         c, rst_out_n, state, e_rst, e_st);
            end
        end
        n_cmp++;
        if (loss_count !== 2'd3 || lock_lost !== 1'b0) begin
            n_err++;
            $display("FAIL soft_noloss got cnt=%0d lost=%b want 3/0", loss_count, lock_lost);
        end
    endtask

    task automatic test_async_reset();
        #2;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({rst_out_n, ready, lock_lost, loss_count, state} !== 9'b0) begin
            n_err++;
            $display("FAIL async_reset got rst=%b rdy=%b lost=%b cnt=%0d st=%0d want all 0",
                     rst_out_n, ready, lock_lost, loss_count, state);
        end
        step();
        resetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_loss_run();
        test_saturate_clear();
        test_soft_rst();
        test_async_reset();
        test_glitch_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pll_rst_seq.md
# pll_rst_seq

Reset sequencer that consumes a PLL's asynchronous `locked` indication and produces staged, synchronous-release reset outputs for one clock domain. It filters lock glitches and releases downstream resets in a fixed order with programmable gaps. On lock loss or a software request it re-asserts all resets for a minimum time, then re-qualifies lock. One instance sits in each clock domain fed by a PLL output.

## Interface

Parameters:
- `LOCK_SYNC_STAGES`, default 2: synchronizer depth for `pll_locked`, minimum 2.
- `LOCK_HOLD`, default 1024: consecutive synced-high cycles required to qualify lock, minimum 1.
- `STAGES`, default 3: number of reset outputs, minimum 1.
- `STAGE_GAP`, default 16: cycles between successive stage releases, minimum 1.
- `MIN_ASSERT`, default 64: minimum cycles all resets stay asserted after a fault or soft reset, minimum 1.
- `CNT_W`, default 8: width of the lock-loss counter.

Ports:
- `clk` in 1: domain clock (a PLL output).
- `resetn` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL lock, asynchronous to `clk`.
- `soft_rst` in 1: synchronous request; high for one cycle re-asserts all resets.
- `clr_lost` in 1: synchronous; clears `lock_lost`.
- `rst_out_n` out STAGES: active-low resets; bit 0 releases first.
- `ready` out 1: high when all stages are released.
- `lock_lost` out 1: sticky flag, set on any lock loss after release began.
- `loss_count` out CNT_W: saturating count of lock losses.
- `state` out 3: current FSM state, for debug.

## Operation

- `pll_locked` passes through `LOCK_SYNC_STAGES` flops to give `lk`. No other path uses the raw input.
- FSM states and encodings:
  - WAIT_LOCK = 0: all resets asserted. Go to HOLD when `lk` = 1.
  - HOLD = 1: counter increments on each `lk` = 1 cycle. If `lk` = 0, return to WAIT_LOCK with no loss counted. When the counter reaches `LOCK_HOLD`, go to RELEASE.
  - RELEASE = 2: deassert `rst_out_n[0]`, then each further bit every `STAGE_GAP` cycles. When the last bit is released, go to RUN.
  - RUN = 3: `ready` = 1.
  - ASSERT = 4: all resets asserted, `ready` = 0. After `MIN_ASSERT` cycles, go to WAIT_LOCK.
- Fault in RELEASE or RUN: when `lk` = 0, go to ASSERT, set `lock_lost`, and increment `loss_count` (saturating at all-ones).
- `soft_rst` = 1 in HOLD, RELEASE or RUN: go to ASSERT with no loss counted.
- `soft_rst` is ignored in WAIT_LOCK and ASSERT. A held `soft_rst` does not extend ASSERT.
- Simultaneous lock loss and `soft_rst`: treated as a lock loss and counted.
- Simultaneous `clr_lost` and a new loss: set wins.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Internal counters are sized `$clog2(max(LOCK_HOLD, STAGE_GAP, MIN_ASSERT) + 1)`.

## Timing

- Values while `resetn` = 0: state WAIT_LOCK, `rst_out_n` all 0, `ready` 0, `lock_lost` 0, `loss_count` 0, synchronizer flops 0.
- `resetn` deassertion mid-sequence restarts from WAIT_LOCK.
- Let edge E be the first clock edge that samples `pll_locked` high, with the input held high thereafter.
  - `rst_out_n[0]` rises at E + `LOCK_SYNC_STAGES` + `LOCK_HOLD` + 1.
  - `rst_out_n[i]` rises i·`STAGE_GAP` cycles after bit 0.
  - `ready` rises in the same cycle as `rst_out_n[STAGES-1]`.
- Lock loss sampled low at edge L: all `rst_out_n` go to 0, `ready` goes to 0, `lock_lost` goes to 1 and `loss_count` increments, all at L + `LOCK_SYNC_STAGES` + 1.
- `soft_rst` sampled at edge S: resets assert at S + 1.
- ASSERT occupies exactly `MIN_ASSERT` cycles. Lock requalification in HOLD then starts from zero.
- Glitch filtering: a synced-low pulse of any length during HOLD resets the hold counter.

## Structure

- Shared package holds the FSM state typedef and encodings (WAIT_LOCK, HOLD, RELEASE, RUN, ASSERT) and a `max3` helper constant function.
- One sub-module: `sync_ff`, a parameterized-depth bit synchronizer.
- The rest is a single FSM, one shared down-counter, a stage index register, and output registers.

## Test plan

All scenarios use `LOCK_HOLD` = 8, `STAGES` = 3, `STAGE_GAP` = 4, `MIN_ASSERT` = 5, `CNT_W` = 2.

- Clean lock: raise `pll_locked` at edge 0 -> `rst_out_n` = 001 at cycle 11, 011 at 15, 111 at 19; `ready` rises at 19.
- Glitch in HOLD: drop `pll_locked` for 1 cycle at edge 5 -> no release before edge 6 + 2 + 8 + 1 = 17; `loss_count` stays 0.
- Loss in RUN: drop the lock after `ready` -> all resets 0 and `lock_lost` 1 after 3 cycles; `loss_count` = 1; state ASSERT for 5 cycles, then WAIT_LOCK.
- Saturation and clear: 4 losses -> `loss_count` = 3; `clr_lost` in the same cycle as a loss -> `lock_lost` stays 1.
- Soft reset: pulse `soft_rst` in RUN -> resets 0 next cycle, `loss_count` unchanged, full re-release 5 + 8 + 1 cycles after entering ASSERT with lock held.
- Async reset mid-RELEASE: assert `resetn` = 0 -> all outputs take their reset values immediately, with no clock edge.
